// File: rtl/xcore_iram_arbiter_if.sv
// Bus bundle between the IRAM arbiter and its three neighbours: IF fetch, loader/debug, IRAM macro.
// slave = arbiter side, master = environment side.
interface xcore_iram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [DW-1:0] o_if_rdata;

  logic          i_ld_req;
  logic          i_ld_we;
  logic [AW-1:0] i_ld_addr;
  logic [DW-1:0] i_ld_wdata;
  logic          o_ld_gnt;
  logic          o_ld_rvalid;
  logic [DW-1:0] o_ld_rdata;

  logic          o_ram_en;
  logic          o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [DW-1:0] o_ram_wdata;
  logic [DW-1:0] i_ram_rdata;

  logic          o_busy;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
    output o_ld_gnt, o_ld_rvalid, o_ld_rdata,
    output o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    input  i_ram_rdata,
    output o_busy
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ld_req, i_ld_we, i_ld_addr, i_ld_wdata,
    input  o_ld_gnt, o_ld_rvalid, o_ld_rdata,
    input  o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
    output i_ram_rdata,
    input  o_busy
  );
endinterface

// File: rtl/xcore_iram_arbiter.sv
// IRAM arbiter: fetch vs. loader/debug sharing one single-port sync RAM, IDLE->ACC->RSP per access.
// Define XCORE_IRAM_LDR_AGE_EN to let a starved loader win after LDR_MAX_WAIT lost arbitrations.
module xcore_iram_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LDR_MAX_WAIT = 8
) (
  input  logic                 i_sys_clk,
  input  logic                 i_sys_rst,
  xcore_iram_arbiter_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  typedef struct packed {
    logic          ld;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  if (LDR_MAX_WAIT < 1) begin : g_cfg_err
    $error("xcore_iram_arbiter: LDR_MAX_WAIT must be >= 1");
  end

  logic [1:0] state;
  logic       own_ld;
  logic       any_req;
  logic       ld_win;
  acc_t       win;

  assign any_req = bus.i_if_req | bus.i_ld_req;

`ifdef XCORE_IRAM_LDR_AGE_EN
  localparam int CW = $clog2(LDR_MAX_WAIT + 1);
  logic [CW-1:0] age;
  logic          aged;

  assign aged   = (age == CW'(LDR_MAX_WAIT));
  assign ld_win = bus.i_ld_req & (~bus.i_if_req | aged);

  // Counts only arbitrations the loader actually lost.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst)                               age <= '0;
    else if (state == S_IDLE && any_req) begin
      if (ld_win)                                 age <= '0;
      else if (bus.i_ld_req && !aged)             age <= age + 1'b1;
    end
  end
`else
  assign ld_win = bus.i_ld_req & ~bus.i_if_req;
`endif

  always_comb begin
    win = '0;
    if (ld_win) begin
      win.ld    = 1'b1;
      win.we    = bus.i_ld_we;
      win.addr  = bus.i_ld_addr;
      win.wdata = bus.i_ld_wdata;
    end else begin
      win.addr  = bus.i_if_addr;
    end
  end

  // RAM-side regs are pulses: they hold the latched access for ACC only and are 0 elsewhere.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state           <= S_IDLE;
      own_ld          <= 1'b0;
      bus.o_if_gnt    <= 1'b0;
      bus.o_ld_gnt    <= 1'b0;
      bus.o_if_rvalid <= 1'b0;
      bus.o_ld_rvalid <= 1'b0;
      bus.o_ram_en    <= 1'b0;
      bus.o_ram_we    <= 1'b0;
      bus.o_ram_addr  <= '0;
      bus.o_ram_wdata <= '0;
    end else begin
      bus.o_if_gnt    <= 1'b0;
      bus.o_ld_gnt    <= 1'b0;
      bus.o_if_rvalid <= 1'b0;
      bus.o_ld_rvalid <= 1'b0;
      bus.o_ram_en    <= 1'b0;
      bus.o_ram_we    <= 1'b0;
      bus.o_ram_addr  <= '0;
      bus.o_ram_wdata <= '0;
      case (state)
        S_IDLE: if (any_req) begin
          state           <= S_ACC;
          own_ld          <= win.ld;
          bus.o_if_gnt    <= ~win.ld;
          bus.o_ld_gnt    <= win.ld;
          bus.o_ram_en    <= 1'b1;
          bus.o_ram_we    <= win.we;
          bus.o_ram_addr  <= win.addr;
          bus.o_ram_wdata <= win.wdata;
        end
        S_ACC: begin
          state           <= S_RSP;
          bus.o_if_rvalid <= ~own_ld;
          bus.o_ld_rvalid <= own_ld & ~bus.o_ram_we;
        end
        S_RSP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sync RAM data lands in RSP, the same cycle rvalid is high.
  assign bus.o_if_rdata = bus.o_if_rvalid ? bus.i_ram_rdata : '0;
  assign bus.o_ld_rdata = bus.o_ld_rvalid ? bus.i_ram_rdata : '0;
  assign bus.o_busy     = (state != S_IDLE);
endmodule
